link_arbiter: RTL and testbench

//  Shares one four-phase handshake sender (6-bit chunk link) between NSRC frame producers.

---
 rtl/link_arbiter.sv | 134 +++++++++++++
 tb/tb_link_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one four-phase chunk sender among NSRC frame producers.
// Latches the winner's frame, counts ack falling edges to end-of-frame, aborts on receiver stall.
module link_arbiter #(
  parameter int NSRC    = 4,
  parameter int W       = 6,
  parameter int CHUNK   = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk_sender,
  input  logic              rst,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [NSRC*W-1:0] src_data,
  output logic [NSRC-1:0]   src_done,
  output logic [NSRC-1:0]   grant,
  output logic [W-1:0]      link_data,
  output logic              link_write_en,
  input  logic              link_ack,
  output logic              busy,
  output logic              timeout_err
);

  localparam int NCHK = (W + CHUNK - 1) / CHUNK;
  localparam int CW   = $clog2(NCHK + 1);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW   = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t          state;
  logic            load_cnt;
  logic            ack_q;
  logic [CW-1:0]   chunk_cnt;
  logic [TW-1:0]   idle_cnt;
  logic [IW-1:0]   rr_last;

  logic            ack_fall;
  logic [CW-1:0]   chunk_nxt;
  logic [TW-1:0]   idle_nxt;
  logic            timeout_hit;
  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [NSRC-1:0] pick_onehot;
  int              idx;

  assign ack_fall    = ack_q & ~link_ack;
  assign chunk_nxt   = chunk_cnt + CW'(1);
  assign idle_nxt    = (idle_cnt == '1) ? idle_cnt : idle_cnt + TW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (idle_nxt == TW'(TIMEOUT));

  // Scan starts just after the last winner so every waiting requester is served in turn.
  always_comb begin
    pick        = rr_last;
    pick_vld    = 1'b0;
    idx         = 0;
    pick_onehot = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = (int'(rr_last) + k) % NSRC;
      if (!pick_vld && src_valid[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
    pick_onehot[pick] = 1'b1;
  end

  always_ff @(posedge clk_sender) begin
    if (rst) begin
      state         <= IDLE;
      load_cnt      <= 1'b0;
      ack_q         <= 1'b0;
      chunk_cnt     <= '0;
      idle_cnt      <= '0;
      rr_last       <= IW'(NSRC - 1);
      src_done      <= '0;
      grant         <= '0;
      link_data     <= '0;
      link_write_en <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      ack_q       <= link_ack;
      src_done    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant     <= pick_onehot;
            link_data <= src_data[int'(pick)*W +: W];
            rr_last   <= pick;
            busy      <= 1'b1;
            load_cnt  <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (load_cnt) begin
            load_cnt      <= 1'b0;
            link_write_en <= 1'b1;
            state         <= SEND;
          end else begin
            load_cnt <= 1'b1;
          end
        end
        SEND: begin
          // An ack edge both advances the frame and proves the receiver is alive.
          if (ack_fall) begin
            chunk_cnt <= chunk_nxt;
            idle_cnt  <= '0;
            if (chunk_nxt == CW'(NCHK)) begin
              link_write_en <= 1'b0;
              src_done      <= grant;
              state         <= GAP;
            end
          end else if (timeout_hit) begin
            link_write_en <= 1'b0;
            timeout_err   <= 1'b1;
            state         <= GAP;
          end else begin
            idle_cnt <= idle_nxt;
          end
        end
        GAP: begin
          chunk_cnt <= '0;
          idle_cnt  <= '0;
          grant     <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench: dut_a is the single-chunk link with a short timeout, dut_b a three-chunk frame.
module tb_link_arbiter;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  a_valid, b_valid;
  logic [23:0] a_data;
  logic [55:0] b_data;
  logic [3:0]  a_done, a_grant, b_done, b_grant;
  logic [5:0]  a_ldata;
  logic [13:0] b_ldata;
  logic        a_wen, a_ack, a_busy, a_terr;
  logic        b_wen, b_ack, b_busy, b_terr;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;

  link_arbiter #(.NSRC(4), .W(6), .CHUNK(6), .TIMEOUT(16)) dut_a (
    .clk_sender(clk), .rst(rst_a), .src_valid(a_valid), .src_data(a_data),
    .src_done(a_done), .grant(a_grant), .link_data(a_ldata), .link_write_en(a_wen),
    .link_ack(a_ack), .busy(a_busy), .timeout_err(a_terr));

  link_arbiter #(.NSRC(4), .W(14), .CHUNK(6), .TIMEOUT(0)) dut_b (
    .clk_sender(clk), .rst(rst_b), .src_valid(b_valid), .src_data(b_data),
    .src_done(b_done), .grant(b_grant), .link_data(b_ldata), .link_write_en(b_wen),
    .link_ack(b_ack), .busy(b_busy), .timeout_err(b_terr));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1; tick(); rst_b = 1'b0;
  endtask

  task automatic pulse_a();
    a_ack = 1'b1; tick(); a_ack = 1'b0; tick();
  endtask

  task automatic pulse_b();
    b_ack = 1'b1; tick(); b_ack = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    a_valid = '0; b_valid = '0; a_data = '0; b_data = '0; a_ack = 1'b0; b_ack = 1'b0;
    tick(); tick();
    vecs++; if ({a_grant, a_done, a_ldata, a_wen, a_busy, a_terr} !== 17'h0) begin
      $display("FAIL reset_a_outputs: got %h want 0", {a_grant, a_done, a_ldata, a_wen, a_busy, a_terr}); errs++; end
    vecs++; if ({b_grant, b_done, b_ldata, b_wen, b_busy, b_terr} !== 25'h0) begin
      $display("FAIL reset_b_outputs: got %h want 0", {b_grant, b_done, b_ldata, b_wen, b_busy, b_terr}); errs++; end
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    vecs++; if ({a_grant, a_busy, b_grant, b_busy} !== 10'h0) begin
      $display("FAIL idle_no_request: got %h want 0", {a_grant, a_busy, b_grant, b_busy}); errs++; end
  endtask

  task automatic test_single();
    a_data[5:0] = 6'h2A; a_valid = 4'b0001;
    tick();
    vecs++; if (a_grant !== 4'b0001) begin $display("FAIL single_grant: got %b want 0001", a_grant); errs++; end
    vecs++; if (a_ldata !== 6'h2A) begin $display("FAIL single_data: got %h want 2a", a_ldata); errs++; end
    vecs++; if ({a_wen, a_busy} !== 2'b01) begin $display("FAIL single_load1: got wen,busy=%b want 01", {a_wen, a_busy}); errs++; end
    tick();
    vecs++; if (a_wen !== 1'b0) begin $display("FAIL single_load2_wen: got %b want 0", a_wen); errs++; end
    tick();
    vecs++; if (a_wen !== 1'b1) begin $display("FAIL single_send_wen: got %b want 1", a_wen); errs++; end
    a_ack = 1'b1; tick();
    vecs++; if ({a_done, a_wen} !== 5'b00001) begin $display("FAIL single_ack_high: got done,wen=%b want 00001", {a_done, a_wen}); errs++; end
    a_ack = 1'b0; tick();
    vecs++; if ({a_done, a_wen} !== 5'b00010) begin $display("FAIL single_done: got done,wen=%b want 00010", {a_done, a_wen}); errs++; end
    a_valid = '0; tick();
    vecs++; if ({a_done, a_grant, a_busy} !== 9'h0) begin $display("FAIL single_after_gap: got %b want 0", {a_done, a_grant, a_busy}); errs++; end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    logic [5:0] exp_d;
    reset_a();
    for (int i = 0; i < 4; i++) a_data[i*6 +: 6] = 6'h10 + 6'(i);
    a_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      exp_d  = 6'h10 + 6'(k % 4);
      tick();
      vecs++; if (a_grant !== exp_oh) begin $display("FAIL rr_grant[%0d]: got %b want %b", k, a_grant, exp_oh); errs++; end
      vecs++; if (a_ldata !== exp_d) begin $display("FAIL rr_data[%0d]: got %h want %h", k, a_ldata, exp_d); errs++; end
      tick(); tick();
      pulse_a();
      vecs++; if (a_done !== exp_oh) begin $display("FAIL rr_done[%0d]: got %b want %b", k, a_done, exp_oh); errs++; end
      tick();
      vecs++; if (a_grant !== 4'b0000) begin $display("FAIL rr_idle[%0d]: got %b want 0000", k, a_grant); errs++; end
    end
    a_valid = '0;
    reset_a();
  endtask

  task automatic test_multi_chunk();
    reset_b();
    b_data[13:0] = 14'h2ABC; b_valid = 4'b0001;
    tick();
    vecs++; if (b_grant !== 4'b0001) begin $display("FAIL mc_grant: got %b want 0001", b_grant); errs++; end
    vecs++; if (b_ldata !== 14'h2ABC) begin $display("FAIL mc_data: got %h want 2abc", b_ldata); errs++; end
    tick(); tick();
    pulse_b(); pulse_b();
    vecs++; if ({b_done, b_wen, b_busy} !== 6'b000011) begin $display("FAIL mc_two_edges: got done,wen,busy=%b want 000011", {b_done, b_wen, b_busy}); errs++; end
    pulse_b();
    vecs++; if ({b_done, b_wen} !== 5'b00010) begin $display("FAIL mc_three_edges: got done,wen=%b want 00010", {b_done, b_wen}); errs++; end
    b_valid = '0; tick();
  endtask

  task automatic test_timeout();
    reset_a();
    a_data[5:0] = 6'h01; a_data[11:6] = 6'h02; a_valid = 4'b0011;
    tick();
    vecs++; if (a_grant !== 4'b0001) begin $display("FAIL to_grant0: got %b want 0001", a_grant); errs++; end
    tick(); tick();
    repeat (15) tick();
    vecs++; if ({a_wen, a_terr} !== 2'b10) begin $display("FAIL to_before: got wen,terr=%b want 10", {a_wen, a_terr}); errs++; end
    tick();
    vecs++; if ({a_terr, a_wen, a_done} !== 6'b100000) begin $display("FAIL to_pulse: got terr,wen,done=%b want 100000", {a_terr, a_wen, a_done}); errs++; end
    vecs++; if (a_grant !== 4'b0001) begin $display("FAIL to_grant_held: got %b want 0001", a_grant); errs++; end
    a_valid = 4'b0010; tick();
    vecs++; if ({a_terr, a_grant, a_busy} !== 6'h0) begin $display("FAIL to_idle: got %b want 0", {a_terr, a_grant, a_busy}); errs++; end
    tick();
    vecs++; if (a_grant !== 4'b0010) begin $display("FAIL to_next_grant: got %b want 0010", a_grant); errs++; end
    a_valid = '0;
    reset_a();
  endtask

  task automatic test_reset_mid_send();
    reset_b();
    b_data[13:0] = 14'h0123; b_valid = 4'b0001;
    tick(); tick(); tick();
    pulse_b();
    vecs++; if (b_wen !== 1'b1) begin $display("FAIL rs_in_send: got wen=%b want 1", b_wen); errs++; end
    rst_b = 1'b1; b_valid = 4'b0110; b_data[27:14] = 14'h1111;
    tick();
    vecs++; if ({b_grant, b_wen, b_busy} !== 6'h0) begin $display("FAIL rs_cleared: got %b want 0", {b_grant, b_wen, b_busy}); errs++; end
    rst_b = 1'b0; tick();
    vecs++; if (b_grant !== 4'b0010) begin $display("FAIL rs_first_grant: got %b want 0010", b_grant); errs++; end
    vecs++; if (b_ldata !== 14'h1111) begin $display("FAIL rs_data: got %h want 1111", b_ldata); errs++; end
    tick(); tick();
    pulse_b(); pulse_b();
    vecs++; if ({b_done, b_wen} !== 5'b00001) begin $display("FAIL rs_chunk_restart: got done,wen=%b want 00001", {b_done, b_wen}); errs++; end
    pulse_b();
    vecs++; if (b_done !== 4'b0010) begin $display("FAIL rs_done: got %b want 0010", b_done); errs++; end
    b_valid = '0; tick();
  endtask

  task automatic test_valid_drop();
    reset_a();
    a_data[17:12] = 6'h15; a_valid = 4'b0100;
    tick();
    vecs++; if (a_grant !== 4'b0100) begin $display("FAIL vd_grant: got %b want 0100", a_grant); errs++; end
    tick(); tick();
    a_valid = '0; a_data[17:12] = 6'h3F;
    tick();
    vecs++; if ({a_grant, a_ldata, a_wen} !== {4'b0100, 6'h15, 1'b1}) begin
      $display("FAIL vd_hold: got %b want %b", {a_grant, a_ldata, a_wen}, {4'b0100, 6'h15, 1'b1}); errs++; end
    pulse_a();
    vecs++; if (a_done !== 4'b0100) begin $display("FAIL vd_done: got %b want 0100", a_done); errs++; end
    tick(); tick();
    vecs++; if ({a_done, a_grant, a_busy} !== 9'h0) begin $display("FAIL vd_no_regrant: got %b want 0", {a_done, a_grant, a_busy}); errs++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_multi_chunk();
    test_timeout();
    test_reset_mid_send();
    test_valid_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
